// File: rtl/reg_status_ctrl_if.sv
// Issue, lookup, commit and register-file port bundle of the register-status controller.
// The core or testbench drives the master side; the controller uses the slave side.
interface reg_status_ctrl_if #(
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned XLEN      = 32
);
    logic                 issue_valid;
    logic [4:0]           issue_rd;
    logic [ROB_IDX_W-1:0] issue_tag;
    logic [4:0]           issue_rs1;
    logic [4:0]           issue_rs2;
    logic                 rs1_busy;
    logic [ROB_IDX_W-1:0] rs1_tag;
    logic [XLEN-1:0]      rs1_val;
    logic                 rs2_busy;
    logic [ROB_IDX_W-1:0] rs2_tag;
    logic [XLEN-1:0]      rs2_val;
    logic                 commit_valid;
    logic [4:0]           commit_rd;
    logic [ROB_IDX_W-1:0] commit_tag;
    logic [XLEN-1:0]      commit_val;
    logic [4:0]           rf_get_reg_1;
    logic [4:0]           rf_get_reg_2;
    logic [XLEN-1:0]      rf_get_val_1;
    logic [XLEN-1:0]      rf_get_val_2;
    logic [4:0]           rf_set_reg;
    logic [XLEN-1:0]      rf_set_val;
    logic [5:0]           busy_cnt;
    logic [31:0]          commit_cnt;

    modport master (
        output issue_valid, issue_rd, issue_tag, issue_rs1, issue_rs2,
        output commit_valid, commit_rd, commit_tag, commit_val,
        output rf_get_val_1, rf_get_val_2,
        input  rs1_busy, rs1_tag, rs1_val, rs2_busy, rs2_tag, rs2_val,
        input  rf_get_reg_1, rf_get_reg_2, rf_set_reg, rf_set_val,
        input  busy_cnt, commit_cnt
    );

    modport slave (
        input  issue_valid, issue_rd, issue_tag, issue_rs1, issue_rs2,
        input  commit_valid, commit_rd, commit_tag, commit_val,
        input  rf_get_val_1, rf_get_val_2,
        output rs1_busy, rs1_tag, rs1_val, rs2_busy, rs2_tag, rs2_val,
        output rf_get_reg_1, rf_get_reg_2, rf_set_reg, rf_set_val,
        output busy_cnt, commit_cnt
    );
endinterface

// File: rtl/reg_status_ctrl.sv
// Register-status (rename) table for the 32-entry architectural register file.
// Define REG_STATUS_STATS_EN to build the retired-write counter commit_cnt.
module reg_status_ctrl #(
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned XLEN      = 32
) (
    input logic              clk_in,
    input logic              rst_in,
    input logic              rdy_in,
    input logic              flush_in,
    reg_status_ctrl_if.slave bus
);
    typedef struct packed {
        logic                 busy;
        logic [ROB_IDX_W-1:0] tag;
        logic [XLEN-1:0]      val;
    } lookup_t;

    logic [31:0]                    busy_q, busy_d;
    logic [31:0][ROB_IDX_W-1:0]     tag_q, tag_d;
    logic [5:0]                     busy_cnt_q, busy_cnt_d;
    logic                           commit_hit;
    lookup_t                        lk1, lk2;

    assign commit_hit = bus.commit_valid && (bus.commit_rd != 5'd0) &&
                        busy_q[bus.commit_rd] && (tag_q[bus.commit_rd] == bus.commit_tag);

    // Lookups see pre-edge state, with a matching same-cycle commit forwarded.
    function automatic lookup_t lookup(input logic [4:0] rs, input logic [XLEN-1:0] rf_val);
        lookup_t r;
        r = '0;
        if (rs == 5'd0) begin
            r = '0;
        end else if (bus.commit_valid && (bus.commit_rd == rs) && busy_q[rs] &&
                     (tag_q[rs] == bus.commit_tag)) begin
            r.val = bus.commit_val;
        end else if (busy_q[rs]) begin
            r.busy = 1'b1;
            r.tag  = tag_q[rs];
        end else begin
            r.val = rf_val;
        end
        return r;
    endfunction

    always_comb begin
        lk1 = lookup(bus.issue_rs1, bus.rf_get_val_1);
        lk2 = lookup(bus.issue_rs2, bus.rf_get_val_2);
    end

    assign bus.rs1_busy     = lk1.busy;
    assign bus.rs1_tag      = lk1.tag;
    assign bus.rs1_val      = lk1.val;
    assign bus.rs2_busy     = lk2.busy;
    assign bus.rs2_tag      = lk2.tag;
    assign bus.rs2_val      = lk2.val;
    assign bus.rf_get_reg_1 = bus.issue_rs1;
    assign bus.rf_get_reg_2 = bus.issue_rs2;
    assign bus.rf_set_reg   = (bus.commit_valid && rdy_in) ? bus.commit_rd : 5'd0;
    assign bus.rf_set_val   = bus.commit_val;
    assign bus.busy_cnt     = busy_cnt_q;

    always_comb begin
        busy_d     = busy_q;
        tag_d      = tag_q;
        busy_cnt_d = busy_cnt_q;
        if (rdy_in) begin
            if (flush_in) begin
                busy_d = '0;
            end else begin
                if (commit_hit) busy_d[bus.commit_rd] = 1'b0;
                // Issue after commit so a same-register issue keeps the entry busy.
                if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
                    busy_d[bus.issue_rd] = 1'b1;
                    tag_d[bus.issue_rd]  = bus.issue_tag;
                end
            end
            busy_cnt_d = '0;
            for (int i = 0; i < 32; i++) busy_cnt_d = busy_cnt_d + 6'(busy_d[i]);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q     <= '0;
            tag_q      <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            tag_q      <= tag_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

`ifdef REG_STATUS_STATS_EN
    logic [31:0] commit_cnt_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            commit_cnt_q <= '0;
        end else if (rdy_in && bus.commit_valid && (bus.commit_rd != 5'd0)) begin
            commit_cnt_q <= commit_cnt_q + 32'd1;
        end
    end

    assign bus.commit_cnt = commit_cnt_q;
`else
    assign bus.commit_cnt = '0;
`endif
endmodule

// File: tb/tb_reg_status_ctrl.sv
// Directed bench for reg_status_ctrl: stimulus queues expectations, a negedge monitor checks them.
module tb_reg_status_ctrl;
    localparam int unsigned ROB_IDX_W = 4;
    localparam int unsigned XLEN      = 32;

    typedef enum int {
        SRs1Busy, SRs1Tag, SRs1Val, SRs2Busy, SRs2Tag, SRs2Val,
        SRfGet1, SRfGet2, SRfSetReg, SRfSetVal, SBusyCnt, SCommitCnt
    } sig_e;

    typedef struct {
        string       name;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b1;
    logic flush = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_commits = 0;
    exp_t sb[$];

    reg_status_ctrl_if #(.ROB_IDX_W(ROB_IDX_W), .XLEN(XLEN)) bus ();

    reg_status_ctrl #(.ROB_IDX_W(ROB_IDX_W), .XLEN(XLEN)) dut (
        .clk_in  (clk),
        .rst_in  (rst_n),
        .rdy_in  (rdy),
        .flush_in(flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input sig_e s);
        case (s)
            SRs1Busy:   return 32'(bus.rs1_busy);
            SRs1Tag:    return 32'(bus.rs1_tag);
            SRs1Val:    return bus.rs1_val;
            SRs2Busy:   return 32'(bus.rs2_busy);
            SRs2Tag:    return 32'(bus.rs2_tag);
            SRs2Val:    return bus.rs2_val;
            SRfGet1:    return 32'(bus.rf_get_reg_1);
            SRfGet2:    return 32'(bus.rf_get_reg_2);
            SRfSetReg:  return 32'(bus.rf_set_reg);
            SRfSetVal:  return bus.rf_set_val;
            SBusyCnt:   return 32'(bus.busy_cnt);
            SCommitCnt: return bus.commit_cnt;
            default:    return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: outputs are combinational, so everything queued this cycle is valid at negedge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = sb.pop_front();
            act = actual(e.sig);
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_eq(input string name, input sig_e s, input logic [31:0] v);
        sb.push_back('{name: name, sig: s, exp: v});
    endtask

    function automatic logic [31:0] exp_commit_cnt();
`ifdef REG_STATUS_STATS_EN
        return 32'(n_commits);
`else
        return 32'd0;
`endif
    endfunction

    // Advance to just after the next active edge, counting a commit the edge will retire.
    task automatic step();
        if (rst_n && rdy && bus.commit_valid && bus.commit_rd != 5'd0) n_commits++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [4:0] ird, input logic [3:0] itag,
                         input logic cv, input logic [4:0] crd, input logic [3:0] ctag,
                         input logic [31:0] cval);
        bus.issue_valid  = iv;
        bus.issue_rd     = ird;
        bus.issue_tag    = itag;
        bus.commit_valid = cv;
        bus.commit_rd    = crd;
        bus.commit_tag   = ctag;
        bus.commit_val   = cval;
    endtask

    task automatic look(input logic [4:0] rs1, input logic [31:0] v1,
                        input logic [4:0] rs2, input logic [31:0] v2);
        bus.issue_rs1    = rs1;
        bus.rf_get_val_1 = v1;
        bus.issue_rs2    = rs2;
        bus.rf_get_val_2 = v2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        look(0, 0, 0, 0);
        #1;
        expect_eq("reset_busy_cnt", SBusyCnt, 0);
        expect_eq("reset_commit_cnt", SCommitCnt, 0);
        expect_eq("reset_rf_set_reg", SRfSetReg, 0);
        step();
        step();
        rst_n = 1'b1;

        look(5, 32'h1234, 0, 0);
        expect_eq("lk_rs1_busy", SRs1Busy, 0);
        expect_eq("lk_rs1_val", SRs1Val, 32'h1234);
        expect_eq("lk_rf_get_reg_1", SRfGet1, 5);
        expect_eq("lk_busy_cnt", SBusyCnt, 0);
        step();

        drive(1, 3, 7, 0, 0, 0, 0);
        expect_eq("iss3_pre_cnt", SBusyCnt, 0);
        step();

        drive(0, 0, 0, 0, 0, 0, 0);
        look(0, 0, 3, 32'h9);
        expect_eq("x3_busy", SRs2Busy, 1);
        expect_eq("x3_tag", SRs2Tag, 7);
        expect_eq("x3_rf_get_reg_2", SRfGet2, 3);
        expect_eq("x3_busy_cnt", SBusyCnt, 1);
        step();

        drive(0, 0, 0, 1, 3, 7, 32'hCAFE);
        look(3, 32'h9, 0, 0);
        expect_eq("byp_rs1_busy", SRs1Busy, 0);
        expect_eq("byp_rs1_val", SRs1Val, 32'hCAFE);
        expect_eq("byp_set_reg", SRfSetReg, 3);
        expect_eq("byp_set_val", SRfSetVal, 32'hCAFE);
        step();

        drive(0, 0, 0, 0, 0, 0, 0);
        look(3, 32'h99, 0, 0);
        expect_eq("clr3_busy_cnt", SBusyCnt, 0);
        expect_eq("clr3_rs1_val", SRs1Val, 32'h99);
        expect_eq("clr3_commit_cnt", SCommitCnt, exp_commit_cnt());
        step();

        drive(1, 4, 1, 0, 0, 0, 0);
        step();
        drive(1, 4, 2, 0, 0, 0, 0);
        look(4, 0, 0, 0);
        expect_eq("x4_first_tag", SRs1Tag, 1);
        step();
        drive(0, 0, 0, 1, 4, 1, 32'h44);
        expect_eq("stale_set_reg", SRfSetReg, 4);
        expect_eq("stale_rs1_busy", SRs1Busy, 1);
        expect_eq("stale_rs1_tag", SRs1Tag, 2);
        step();
        drive(1, 6, 3, 0, 0, 0, 0);
        expect_eq("x4_still_busy", SRs1Busy, 1);
        expect_eq("x4_still_tag2", SRs1Tag, 2);
        expect_eq("x4_cnt", SBusyCnt, 1);
        step();

        drive(1, 6, 5, 1, 6, 3, 32'h66);
        look(0, 0, 6, 0);
        expect_eq("x6_fwd_busy", SRs2Busy, 0);
        expect_eq("x6_fwd_val", SRs2Val, 32'h66);
        expect_eq("x6_pre_cnt", SBusyCnt, 2);
        step();

        drive(1, 0, 9, 0, 0, 0, 0);
        expect_eq("x6_reissued_busy", SRs2Busy, 1);
        expect_eq("x6_reissued_tag", SRs2Tag, 5);
        expect_eq("x6_cnt", SBusyCnt, 2);
        step();

        rdy = 1'b0;
        drive(1, 8, 3, 1, 4, 2, 32'h77);
        look(0, 32'hDEAD, 4, 0);
        expect_eq("rd0_cnt", SBusyCnt, 2);
        expect_eq("x0_busy", SRs1Busy, 0);
        expect_eq("x0_val", SRs1Val, 0);
        expect_eq("x0_tag", SRs1Tag, 0);
        expect_eq("stall_set_reg", SRfSetReg, 0);
        expect_eq("stall_lookup_busy", SRs2Busy, 0);
        expect_eq("stall_lookup_val", SRs2Val, 32'h77);
        step();

        rdy = 1'b1;
        drive(1, 1, 1, 1, 4, 2, 32'h88);
        look(8, 32'h5, 0, 0);
        expect_eq("stall_x8_busy", SRs1Busy, 0);
        expect_eq("stall_cnt", SBusyCnt, 2);
        expect_eq("stall_commit_cnt", SCommitCnt, exp_commit_cnt());
        step();
        drive(1, 2, 2, 1, 6, 5, 32'h66);
        step();
        drive(1, 9, 3, 0, 0, 0, 0);
        step();

        flush = 1'b1;
        drive(1, 10, 4, 1, 2, 2, 32'h55);
        look(1, 0, 9, 0);
        expect_eq("pre_flush_cnt", SBusyCnt, 3);
        expect_eq("pre_flush_x1", SRs1Busy, 1);
        expect_eq("flush_set_reg", SRfSetReg, 2);
        expect_eq("flush_set_val", SRfSetVal, 32'h55);
        step();

        flush = 1'b0;
        drive(1, 5, 6, 0, 0, 0, 0);
        look(10, 32'hA, 9, 32'hB);
        expect_eq("post_flush_cnt", SBusyCnt, 0);
        expect_eq("post_flush_x10", SRs1Busy, 0);
        expect_eq("post_flush_x10_val", SRs1Val, 32'hA);
        expect_eq("post_flush_x9", SRs2Busy, 0);
        expect_eq("post_flush_commit_cnt", SCommitCnt, exp_commit_cnt());
        step();

        drive(0, 0, 0, 0, 0, 0, 0);
        look(5, 32'h3, 0, 0);
        expect_eq("x5_busy", SRs1Busy, 1);
        expect_eq("x5_tag", SRs1Tag, 6);
        expect_eq("x5_cnt", SBusyCnt, 1);
        step();

        rst_n = 1'b0;
        n_commits = 0;
        #1;
        expect_eq("rst_x5_busy", SRs1Busy, 0);
        expect_eq("rst_x5_val", SRs1Val, 32'h3);
        expect_eq("rst_cnt", SBusyCnt, 0);
        expect_eq("rst_commit_cnt", SCommitCnt, 0);
        step();
        rst_n = 1'b1;
        step();

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
